// File: rtl/mips_ex_pkg.sv
// mips_ex_pkg: shared widths, stage state encoding and EX->MEM entry layout
package mips_ex_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic              z;
    logic              v;
    logic              n;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] store_data;
    logic              exc_ov;
  } ex_mem_entry_t;
endpackage

// File: rtl/ex_mem_entry_build.sv
// ex_mem_entry_build: applies the overflow trap rule and packs one EX->MEM entry
module ex_mem_entry_build #(
  parameter int DATA_W = mips_ex_pkg::DATA_W,
  parameter int REG_W = mips_ex_pkg::REG_W
) (
  input  logic [DATA_W-1:0]         i_s,
  input  logic                      i_z,
  input  logic                      i_v,
  input  logic                      i_n,
  input  logic                      i_trap_ov,
  input  logic [REG_W-1:0]          i_rd,
  input  logic                      i_regwrite,
  input  logic                      i_memread,
  input  logic                      i_memwrite,
  input  logic [DATA_W-1:0]         i_store_data,
  output mips_ex_pkg::ex_mem_entry_t o_entry
);
  logic w_trap;
  assign w_trap = i_trap_ov & i_v;
  // A trapped op keeps its result and flags for diagnosis but loses all side effects
  assign o_entry = '{
    s:          i_s,
    z:          i_z,
    v:          i_v,
    n:          i_n,
    rd:         i_rd,
    regwrite:   i_regwrite & ~w_trap,
    memread:    i_memread & ~w_trap,
    memwrite:   i_memwrite & ~w_trap,
    store_data: i_store_data,
    exc_ov:     w_trap
  };
endmodule

// File: rtl/ex_mem_result_stage.sv
// ex_mem_result_stage: EX->MEM register stage with 2-entry skid buffer and overflow trap
module ex_mem_result_stage #(
  parameter int DATA_W = mips_ex_pkg::DATA_W,
  parameter int REG_W = mips_ex_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_S,
  input  logic              in_Z,
  input  logic              in_V,
  input  logic              in_N,
  input  logic              in_trap_ov,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_S,
  output logic              out_Z,
  output logic              out_V,
  output logic              out_N,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_exc_ov
);
  import mips_ex_pkg::*;
  state_t        r_state, w_state_nxt;
  ex_mem_entry_t r_head, r_skid, w_entry;
  logic          w_accept, w_drain, w_head_ld, w_head_from_skid, w_skid_ld;
  ex_mem_entry_build #(.DATA_W(DATA_W), .REG_W(REG_W)) u_build (
    .i_s(in_S), .i_z(in_Z), .i_v(in_V), .i_n(in_N), .i_trap_ov(in_trap_ov),
    .i_rd(in_rd), .i_regwrite(in_regwrite), .i_memread(in_memread),
    .i_memwrite(in_memwrite), .i_store_data(in_store_data), .o_entry(w_entry)
  );
  // in_ready depends only on state (and reset), never on out_ready
  assign in_ready  = ~reset & (r_state != FULL);
  assign out_valid = r_state != EMPTY;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_drain   = out_valid & out_ready;
  always_comb begin
    w_state_nxt      = r_state;
    w_head_ld        = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (flush)
      w_state_nxt = EMPTY;
    else
      case (r_state)
        EMPTY: begin
          w_state_nxt = w_accept ? ONE : EMPTY;
          w_head_ld   = w_accept;
        end
        ONE: begin
          w_state_nxt = w_accept ? (w_drain ? ONE : FULL) : (w_drain ? EMPTY : ONE);
          w_head_ld   = w_accept & w_drain;
          w_skid_ld   = w_accept & ~w_drain;
        end
        FULL: begin
          w_state_nxt      = w_drain ? ONE : FULL;
          w_head_ld        = w_drain;
          w_head_from_skid = 1'b1;
        end
        default: w_state_nxt = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_head_ld) r_head <= w_head_from_skid ? r_skid : w_entry;
      if (w_skid_ld) r_skid <= w_entry;
    end
  end
  assign out_S          = r_head.s;
  assign out_Z          = r_head.z;
  assign out_V          = r_head.v;
  assign out_N          = r_head.n;
  assign out_rd         = r_head.rd;
  assign out_regwrite   = r_head.regwrite;
  assign out_memread    = r_head.memread;
  assign out_memwrite   = r_head.memwrite;
  assign out_store_data = r_head.store_data;
  assign out_exc_ov     = r_head.exc_ov;
endmodule
